operand_fetch: RTL and testbench

//  Decode/operand-fetch stage of the RV32I core; sits between instruction fetch and execute.

---
 rtl/operand_fetch.sv | 127 ++++++++++++
 tb/tb_operand_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: register decode, operand capture with writeback bypass,
// and a busy scoreboard that stalls RAW/WAW hazards against issued, uncompleted writes.
module operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_a1,
    output logic [4:0]      rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            kill_valid,
    input  logic [4:0]      kill_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [4:0]      rs1, rs2, rd;
    logic            use_rs1, use_rs2, use_rd, rd_wen;
    logic [31:0]     busy, busy_next, pend;
    logic            hazard, capture, issue;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign rd    = in_instr[11:7];
    assign rf_a1 = rs1;
    assign rf_a2 = rs2;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (in_instr[6:0])
            OPC_OP:                            {use_rs1, use_rs2, use_rd} = 3'b111;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:    {use_rs1, use_rs2, use_rd} = 3'b101;
            OPC_STORE, OPC_BRANCH:             {use_rs1, use_rs2, use_rd} = 3'b110;
            OPC_LUI, OPC_AUIPC, OPC_JAL:       {use_rs1, use_rs2, use_rd} = 3'b001;
            default:                           {use_rs1, use_rs2, use_rd} = 3'b000;
        endcase
    end

    assign rd_wen = use_rd && (rd != 5'd0);

    // A busy register completing this cycle is no longer pending; the held entry always is.
    always_comb begin
        pend = '0;
        for (int i = 1; i < 32; i++) begin
            pend[i] = (busy[i] && !(wb_wen && wb_rd == 5'(i)) && !(kill_valid && kill_rd == 5'(i)))
                   || (out_valid && out_rd_wen && out_rd == 5'(i));
        end
    end

    assign hazard   = (use_rs1 && pend[rs1]) || (use_rs2 && pend[rs2]) || (rd_wen && pend[rd]);
    assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;
    assign issue    = out_valid && out_ready && !flush;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (use_rs1 && rs1 != 5'd0) rs1_val = (wb_wen && wb_rd == rs1) ? wb_data : rf_rd1;
        if (use_rs2 && rs2 != 5'd0) rs2_val = (wb_wen && wb_rd == rs2) ? wb_data : rf_rd2;
    end

    // Clears first so that a same-cycle set of the same bit wins.
    always_comb begin
        busy_next = busy;
        if (wb_wen)             busy_next[wb_rd]  = 1'b0;
        if (kill_valid)         busy_next[kill_rd] = 1'b0;
        if (issue && out_rd_wen) busy_next[out_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_wen  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= rd_wen ? rd : 5'd0;
            out_rd_wen  <= rd_wen;
        end else if (issue) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch: a list of in-flight destination registers and a
// register file array predict in_ready, captured operands and output-register behaviour.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_rd_wen;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .kill_valid(kill_valid), .kill_rd(kill_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen)
    );

    // Register file seen by the stage; x0 holds junk so the x0 -> 0 rule is exercised.
    logic [31:0] regfile [32];
    assign rf_rd1 = regfile[rf_a1];
    assign rf_rd2 = regfile[rf_a2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: held entry and list of issued, uncompleted destinations.
    bit          m_valid;
    logic [31:0] m_instr, m_pc, m_rs1v, m_rs2v;
    logic [4:0]  m_rd;
    bit          m_rdwen;
    int          inflight[$];

    logic [6:0] opcs [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
                              7'b0001111};

    // {reads rs1, reads rs2, writes rd}
    function automatic logic [2:0] reg_usage(input logic [6:0] opc);
        case (opc)
            7'b0110011:                         return 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: return 3'b101;
            7'b0100011, 7'b1100011:             return 3'b110;
            7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;
            default:                            return 3'b000;
        endcase
    endfunction

    function automatic bit in_flight(input logic [4:0] r);
        foreach (inflight[i]) if (inflight[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (in_flight(r) && !(wb_wen && wb_rd == r) && !(kill_valid && kill_rd == r))
            || (m_valid && m_rdwen && m_rd == r);
    endfunction

    function automatic logic [31:0] src_val(input bit used, input logic [4:0] r);
        if (!used || r == 5'd0) return 32'd0;
        if (wb_wen && wb_rd == r) return wb_data;
        return regfile[r];
    endfunction

    task automatic drive_random();
        int i;
        in_valid   = ($urandom_range(9) < 7);
        in_instr   = {7'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)), 3'($urandom),
                      5'($urandom_range(7)), opcs[$urandom_range(10)]};
        in_pc      = $urandom;
        out_ready  = ($urandom_range(9) < 6);
        flush      = ($urandom_range(19) == 0);
        wb_wen     = 1'b0;
        kill_valid = 1'b0;
        wb_rd      = 5'($urandom);
        kill_rd    = 5'($urandom);
        wb_data    = $urandom;
        if (inflight.size() > 0 && $urandom_range(9) < 4) begin
            i = $urandom_range(inflight.size() - 1);
            wb_wen = 1'b1;
            wb_rd  = 5'(inflight[i]);
        end
        if (inflight.size() > 0 && $urandom_range(9) < 2) begin
            i = $urandom_range(inflight.size() - 1);
            if (!(wb_wen && wb_rd == 5'(inflight[i]))) begin
                kill_valid = 1'b1;
                kill_rd    = 5'(inflight[i]);
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_out_valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check({pfx, "_instr_pc"}, {out_instr, out_pc}, {m_instr, m_pc});
            check({pfx, "_operands"}, {out_rs1_val, out_rs2_val}, {m_rs1v, m_rs2v});
            check({pfx, "_rd"}, 64'({out_rd, out_rd_wen}), 64'({m_rd, m_rdwen}));
        end
    endtask

    task automatic step();
        logic [2:0]  u;
        logic [4:0]  rs1, rs2, rd;
        bit          rdw, haz, exp_ready, cap, iss;
        logic [31:0] c1, c2;
        @(negedge clk);
        drive_random();
        #1;
        u   = reg_usage(in_instr[6:0]);
        rs1 = in_instr[19:15];
        rs2 = in_instr[24:20];
        rd  = in_instr[11:7];
        rdw = u[0] && rd != 5'd0;
        haz = (u[2] && pending(rs1)) || (u[1] && pending(rs2)) || (rdw && pending(rd));
        exp_ready = !flush && !haz && (!m_valid || out_ready);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("rf_addr", 64'({rf_a1, rf_a2}), 64'({rs1, rs2}));
        cap = in_valid && exp_ready;
        iss = m_valid && out_ready && !flush;
        c1  = src_val(u[2], rs1);
        c2  = src_val(u[1], rs2);
        @(posedge clk);
        #1;
        for (int k = inflight.size() - 1; k >= 0; k--)
            if ((wb_wen && inflight[k] == int'(wb_rd)) || (kill_valid && inflight[k] == int'(kill_rd)))
                inflight.delete(k);
        if (iss && m_rdwen) inflight.push_back(int'(m_rd));
        if (wb_wen && wb_rd != 5'd0) regfile[wb_rd] = wb_data;
        if (flush) m_valid = 1'b0;
        else if (cap) begin
            m_valid = 1'b1;
            m_instr = in_instr;
            m_pc    = in_pc;
            m_rs1v  = c1;
            m_rs2v  = c2;
            m_rd    = rdw ? rd : 5'd0;
            m_rdwen = rdw;
        end else if (iss) m_valid = 1'b0;
        check_outputs("run");
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_words", {out_instr, out_pc}, 64'd0);
        check("rst_out_ops", {out_rs1_val, out_rs2_val}, 64'd0);
        check("rst_out_rd", 64'({out_rd, out_rd_wen}), 64'd0);
        m_valid = 1'b0;
        m_instr = '0; m_pc = '0; m_rs1v = '0; m_rs2v = '0; m_rd = '0; m_rdwen = 1'b0;
        inflight.delete();
        in_valid = 1'b0; wb_wen = 1'b0; kill_valid = 1'b0; flush = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_hold_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit did_mid_reset = 1'b0;
        rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0; kill_valid = 1'b0; kill_rd = '0;
        flush = 1'b0; out_ready = 1'b0;
        for (int r = 0; r < 32; r++) regfile[r] = $urandom | 32'h1;
        apply_reset(3);
        for (int n = 0; n < 3000; n++) begin
            step();
            if (n >= 1500 && !did_mid_reset && m_valid && in_flight(m_rd) == 1'b0) begin
                did_mid_reset = 1'b1;
                apply_reset(2);
            end
        end
        check("mid_reset_done", 64'(did_mid_reset), 64'd1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
